// File: rtl/uart_tx_core_pkg.sv
// Shared types for the UART transmit path: parity modes, FSM states and default frame width.
package uart_tx_core_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // The reserved encoding falls back to no parity bit.
    function automatic logic parity_enabled(input parity_e mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// Host-side handshake and serial-line bundle of the UART transmitter.
interface uart_tx_core_if
    import uart_tx_core_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] TX_DIN;
    logic                  TX_VALID;
    logic                  TX_READY;
    logic [1:0]            PARITY_SEL;
    logic                  STOP2;
    logic                  TX_DATA;
    logic                  TX_BUSY;

    modport master (
        output TX_DIN, TX_VALID, PARITY_SEL, STOP2,
        input  TX_READY, TX_DATA, TX_BUSY
    );

    modport slave (
        input  TX_DIN, TX_VALID, PARITY_SEL, STOP2,
        output TX_READY, TX_DATA, TX_BUSY
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last cycle of each period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt;

    assign tick = !clr && (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: valid/ready intake, start/data/parity/stop framing, registered serial output.
module uart_tx_core
    import uart_tx_core_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           TX_CLK,
    input  logic           TX_RST_N,
    uart_tx_core_if.slave  bus
);
    localparam int BC_W = $clog2(DATA_WIDTH);

    tx_state_e             state_q, state_d;
    logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  line_q, line_d;
    logic                  tick;
    logic                  baud_clr;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] word, input parity_e mode);
        return (^word) ^ (mode == PAR_ODD);
    endfunction

    assign baud_clr     = (state_q == ST_IDLE);
    assign bus.TX_READY = (state_q == ST_IDLE);
    assign bus.TX_BUSY  = (state_q != ST_IDLE);
    assign bus.TX_DATA  = line_q;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (TX_CLK),
        .rst_n(TX_RST_N),
        .clr  (baud_clr),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.TX_VALID) begin
                    state_d   = ST_START;
                    bit_cnt_d = '0;
                    shreg_d   = bus.TX_DIN;
                    par_en_d  = parity_enabled(parity_e'(bus.PARITY_SEL));
                    par_bit_d = calc_parity(bus.TX_DIN, parity_e'(bus.PARITY_SEL));
                    stop2_d   = bus.STOP2;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == BC_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop2_q && (bit_cnt_q == '0)) begin
                        bit_cnt_d = BC_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level is derived from the next state so the flop presents each bit on its first cycle.
    always_comb begin
        line_d = 1'b1;
        unique case (state_d)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shreg_d[0];
            ST_PARITY: line_d = par_bit_d;
            default:   line_d = 1'b1;
        endcase
    end

    always_ff @(posedge TX_CLK or negedge TX_RST_N) begin
        if (!TX_RST_N) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            line_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            line_q    <= line_d;
        end
    end

    always_ff @(posedge TX_CLK) begin
        shreg_q   <= shreg_d;
        par_en_q  <= par_en_d;
        par_bit_q <= par_bit_d;
        stop2_q   <= stop2_d;
    end
endmodule

// File: tb/tb_uart_tx_core.sv
// Directed and randomized frame checks of uart_tx_core against a bit-list frame model.
module tb_uart_tx_core;
    localparam int DW  = 8;
    localparam int CPB = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   exp_bits[$];

    uart_tx_core_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_core #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .TX_CLK  (clk),
        .TX_RST_N(rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame as a list of line levels, one per bit period.
    task automatic build_frame(input logic [DW-1:0] w, input logic [1:0] psel, input logic st2);
        int ones;
        ones = $countones(w);
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_bits.push_back(w[i]);
        if (psel == 2'b01) exp_bits.push_back(bit'(ones % 2));
        if (psel == 2'b10) exp_bits.push_back(bit'(1 - (ones % 2)));
        exp_bits.push_back(1'b1);
        if (st2) exp_bits.push_back(1'b1);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting posedge.
    task automatic start_word(input logic [DW-1:0] w, input logic [1:0] psel, input logic st2,
                              input bit keep_valid);
        int n;
        bus.TX_DIN     = w;
        bus.PARITY_SEL = psel;
        bus.STOP2      = st2;
        bus.TX_VALID   = 1'b1;
        n = 0;
        while (!bus.TX_READY && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.TX_READY) chk("accept_timeout", {31'd0, bus.TX_READY}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) bus.TX_VALID = 1'b0;
    endtask

    // Starts on the first frame cycle; ends on the idle cycle after the last stop cycle.
    task automatic check_frame(input string tag);
        int n;
        int low;
        n   = exp_bits.size() * CPB;
        low = 0;
        for (int k = 0; k < n; k++) begin
            chk({tag, "_line"}, {31'd0, bus.TX_DATA}, {31'd0, exp_bits[k / CPB]});
            if (!bus.TX_READY) low++;
            @(negedge clk);
        end
        chk({tag, "_len"}, low, n);
        chk({tag, "_ready_after"}, {31'd0, bus.TX_READY}, 32'd1);
        chk({tag, "_idle_line"}, {31'd0, bus.TX_DATA}, 32'd1);
        chk({tag, "_busy_after"}, {31'd0, bus.TX_BUSY}, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] w;
        logic [1:0]    ps;
        logic          s2;

        clk            = 1'b0;
        rst_n          = 1'b0;
        bus.TX_VALID   = 1'b1;
        bus.TX_DIN     = 8'h55;
        bus.PARITY_SEL = 2'b01;
        bus.STOP2      = 1'b0;

        // Reset held with a pending word
        repeat (5) begin
            @(negedge clk);
            chk("rst_line", {31'd0, bus.TX_DATA}, 32'd1);
            chk("rst_ready", {31'd0, bus.TX_READY}, 32'd1);
            chk("rst_busy", {31'd0, bus.TX_BUSY}, 32'd0);
        end
        rst_n = 1'b1;
        start_word(8'h55, 2'b01, 1'b0, 1'b0);
        build_frame(8'h55, 2'b01, 1'b0);
        check_frame("post_rst");

        // Even parity, one stop
        start_word(8'hA5, 2'b01, 1'b0, 1'b0);
        build_frame(8'hA5, 2'b01, 1'b0);
        check_frame("a5_even");

        // Odd parity, two stops
        start_word(8'hA5, 2'b10, 1'b1, 1'b0);
        build_frame(8'hA5, 2'b10, 1'b1);
        check_frame("a5_odd_s2");

        // No parity
        start_word(8'h3C, 2'b00, 1'b0, 1'b0);
        build_frame(8'h3C, 2'b00, 1'b0);
        check_frame("3c_none");

        // Back-to-back with valid held
        start_word(8'h01, 2'b01, 1'b0, 1'b1);
        bus.TX_DIN     = 8'hFF;
        bus.PARITY_SEL = 2'b10;
        bus.STOP2      = 1'b1;
        build_frame(8'h01, 2'b01, 1'b0);
        check_frame("b2b_first");
        @(posedge clk);
        @(negedge clk);
        bus.TX_VALID = 1'b0;
        build_frame(8'hFF, 2'b10, 1'b1);
        check_frame("b2b_second");

        // Inputs changed mid-frame must not disturb the latched frame
        start_word(8'h96, 2'b10, 1'b0, 1'b0);
        bus.TX_DIN     = 8'h69;
        bus.PARITY_SEL = 2'b00;
        bus.STOP2      = 1'b1;
        build_frame(8'h96, 2'b10, 1'b0);
        check_frame("latched");

        // Randomized frames, reserved parity code included
        for (int f = 0; f < 6; f++) begin
            w  = DW'($urandom);
            ps = 2'($urandom_range(0, 3));
            s2 = 1'($urandom_range(0, 1));
            start_word(w, ps, s2, 1'b0);
            build_frame(w, ps, s2);
            check_frame("rand");
        end

        // Reset during data bit 3
        start_word(8'hA5, 2'b01, 1'b0, 1'b0);
        repeat (18) @(negedge clk);
        chk("pre_abort_line", {31'd0, bus.TX_DATA}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_line", {31'd0, bus.TX_DATA}, 32'd1);
        chk("abort_ready", {31'd0, bus.TX_READY}, 32'd1);
        chk("abort_busy", {31'd0, bus.TX_BUSY}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("recover_ready", {31'd0, bus.TX_READY}, 32'd1);
        w = DW'($urandom);
        start_word(w, 2'b01, 1'b1, 1'b0);
        build_frame(w, 2'b01, 1'b1);
        check_frame("recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
